// File: rtl/udp_tx_noc_in_parser.sv
// UDP TX NoC input parser.
// Accepts a header flit, a metadata flit and msg_len-1 payload flits from the
// NoC. When the flit count agrees with data_length, it emits one packet header
// followed by the payload beats. When it does not agree, it pulses
// err_len_mismatch and silently drains the remaining flits.
//
// Flit layouts (all fields MSB-aligned within DATA_W):
//   header   : [63:0] routing (ignored) | msg_len[MSG_LEN_W] | msg_type[8] (ignored)
//              | packet_id[32] | timestamp[64] | don't care
//   metadata : src_ip[32] | dst_ip[32] | src_port[16] | dst_port[16]
//              | data_length[16] | don't care
// out_udp_hdr   = {src_port, dst_port, length, chksum}
// out_timestamp = {packet_id, timestamp}
module udp_tx_noc_in_parser #(
  parameter int DATA_W    = 512,
  parameter int MSG_LEN_W = 22,
  localparam int PAD_W    = $clog2(DATA_W / 8)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              noc_in_val,
  input  logic [DATA_W-1:0] noc_in_data,
  output logic              noc_in_rdy,
  output logic              out_hdr_val,
  input  logic              out_hdr_rdy,
  output logic [31:0]       out_src_ip,
  output logic [31:0]       out_dst_ip,
  output logic [63:0]       out_udp_hdr,
  output logic [95:0]       out_timestamp,
  output logic              out_data_val,
  input  logic              out_data_rdy,
  output logic [DATA_W-1:0] out_data,
  output logic              out_data_last,
  output logic [PAD_W-1:0]  out_data_padbytes,
  output logic              err_len_mismatch,
  output logic [31:0]       pkt_cnt
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = MSG_LEN_W + 1;

  // Header flit field positions
  localparam int HDR_ML_MSB  = DATA_W - 64 - 1;
  localparam int HDR_PID_MSB = HDR_ML_MSB - MSG_LEN_W - 8;
  localparam int HDR_TS_MSB  = HDR_PID_MSB - 32;

  // Metadata flit field positions
  localparam int MD_SIP_MSB = DATA_W - 1;
  localparam int MD_DIP_MSB = DATA_W - 33;
  localparam int MD_SP_MSB  = DATA_W - 65;
  localparam int MD_DP_MSB  = DATA_W - 81;
  localparam int MD_DL_MSB  = DATA_W - 97;

  typedef enum logic [2:0] {
    ST_HDR,
    ST_META,
    ST_CHECK,
    ST_EMIT_HDR,
    ST_DATA,
    ST_DRAIN
  } state_e;

  state_e               state_q, state_d;
  logic                 live_q;
  logic [CNT_W-1:0]     flits_rem_q, flits_rem_d;
  logic [31:0]          pkt_cnt_q, pkt_cnt_d;
  logic [MSG_LEN_W-1:0] msg_len_q;
  logic [31:0]          pkt_id_q;
  logic [63:0]          ts_q;
  logic [31:0]          src_ip_q, dst_ip_q;
  logic [15:0]          src_port_q, dst_port_q;
  logic [15:0]          data_len_q;
  logic                 hdr_ld, meta_ld;

  logic [CNT_W-1:0]     exp_flits;
  logic [CNT_W-1:0]     len_m1;
  logic                 len_ok;
  logic [PAD_W-1:0]     tail_bytes;
  logic [PAD_W-1:0]     pad_last;

  assign exp_flits  = CNT_W'((32'(data_len_q) + 32'(BYTES - 1)) / 32'(BYTES));
  assign len_m1     = CNT_W'(msg_len_q) - CNT_W'(1);
  assign len_ok     = (msg_len_q != '0) && (exp_flits == len_m1);
  assign tail_bytes = PAD_W'(32'(data_len_q) % 32'(BYTES));
  assign pad_last   = (tail_bytes == '0) ? '0 : PAD_W'(32'(BYTES) - 32'(tail_bytes));

  assign out_src_ip    = src_ip_q;
  assign out_dst_ip    = dst_ip_q;
  assign out_udp_hdr   = {src_port_q, dst_port_q, data_len_q + 16'd8, 16'h0000};
  assign out_timestamp = {pkt_id_q, ts_q};
  assign out_data      = noc_in_data;
  assign pkt_cnt       = pkt_cnt_q;

  // State, counters and post-reset ready enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HDR;
      live_q      <= 1'b0;
      flits_rem_q <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      flits_rem_q <= flits_rem_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  // Capture header and metadata fields on their flit transfers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_len_q  <= '0;
      pkt_id_q   <= '0;
      ts_q       <= '0;
      src_ip_q   <= '0;
      dst_ip_q   <= '0;
      src_port_q <= '0;
      dst_port_q <= '0;
      data_len_q <= '0;
    end else begin
      if (hdr_ld) begin
        msg_len_q <= noc_in_data[HDR_ML_MSB -: MSG_LEN_W];
        pkt_id_q  <= noc_in_data[HDR_PID_MSB -: 32];
        ts_q      <= noc_in_data[HDR_TS_MSB -: 64];
      end
      if (meta_ld) begin
        src_ip_q   <= noc_in_data[MD_SIP_MSB -: 32];
        dst_ip_q   <= noc_in_data[MD_DIP_MSB -: 32];
        src_port_q <= noc_in_data[MD_SP_MSB -: 16];
        dst_port_q <= noc_in_data[MD_DP_MSB -: 16];
        data_len_q <= noc_in_data[MD_DL_MSB -: 16];
      end
    end
  end

  // Next-state logic and handshake outputs
  always_comb begin
    state_d           = state_q;
    flits_rem_d       = flits_rem_q;
    pkt_cnt_d         = pkt_cnt_q;
    hdr_ld            = 1'b0;
    meta_ld           = 1'b0;
    noc_in_rdy        = 1'b0;
    out_hdr_val       = 1'b0;
    out_data_val      = 1'b0;
    out_data_last     = 1'b0;
    out_data_padbytes = '0;
    err_len_mismatch  = 1'b0;

    case (state_q)
      ST_HDR: begin
        // Ready is held off until the first clock edge after reset release
        noc_in_rdy = live_q;
        if (noc_in_val && live_q) begin
          hdr_ld  = 1'b1;
          state_d = ST_META;
        end
      end
      ST_META: begin
        noc_in_rdy = 1'b1;
        if (noc_in_val) begin
          meta_ld = 1'b1;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (len_ok) begin
          flits_rem_d = exp_flits;
          state_d     = ST_EMIT_HDR;
        end else begin
          err_len_mismatch = 1'b1;
          if (msg_len_q == '0 || len_m1 == '0) begin
            flits_rem_d = '0;
            state_d     = ST_HDR;
          end else begin
            flits_rem_d = len_m1;
            state_d     = ST_DRAIN;
          end
        end
      end
      ST_EMIT_HDR: begin
        out_hdr_val = 1'b1;
        if (out_hdr_rdy) begin
          pkt_cnt_d = pkt_cnt_q + 32'd1;
          state_d   = (flits_rem_q == '0) ? ST_HDR : ST_DATA;
        end
      end
      ST_DATA: begin
        out_data_val      = noc_in_val;
        noc_in_rdy        = out_data_rdy;
        out_data_last     = (flits_rem_q == CNT_W'(1));
        out_data_padbytes = out_data_last ? pad_last : '0;
        if (noc_in_val && out_data_rdy) begin
          flits_rem_d = flits_rem_q - CNT_W'(1);
          if (out_data_last) begin
            state_d = ST_HDR;
          end
        end
      end
      ST_DRAIN: begin
        noc_in_rdy = 1'b1;
        if (noc_in_val) begin
          flits_rem_d = flits_rem_q - CNT_W'(1);
          if (flits_rem_q == CNT_W'(1)) begin
            state_d = ST_HDR;
          end
        end
      end
      default: state_d = ST_HDR;
    endcase
  end

endmodule

// File: tb/tb_udp_tx_noc_in_parser.sv
// Randomized self-checking bench for udp_tx_noc_in_parser (DATA_W=512).
// A packet-level model predicts headers, payload beats and error pulses; a
// negedge monitor compares every output transfer against it.
module tb_udp_tx_noc_in_parser;

  logic         clk;
  logic         rst_n;
  logic         noc_in_val;
  logic [511:0] noc_in_data;
  logic         noc_in_rdy;
  logic         out_hdr_val;
  logic         out_hdr_rdy;
  logic [31:0]  out_src_ip;
  logic [31:0]  out_dst_ip;
  logic [63:0]  out_udp_hdr;
  logic [95:0]  out_timestamp;
  logic         out_data_val;
  logic         out_data_rdy;
  logic [511:0] out_data;
  logic         out_data_last;
  logic [5:0]   out_data_padbytes;
  logic         err_len_mismatch;
  logic [31:0]  pkt_cnt;

  udp_tx_noc_in_parser #(.DATA_W(512), .MSG_LEN_W(22)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .noc_in_val        (noc_in_val),
    .noc_in_data       (noc_in_data),
    .noc_in_rdy        (noc_in_rdy),
    .out_hdr_val       (out_hdr_val),
    .out_hdr_rdy       (out_hdr_rdy),
    .out_src_ip        (out_src_ip),
    .out_dst_ip        (out_dst_ip),
    .out_udp_hdr       (out_udp_hdr),
    .out_timestamp     (out_timestamp),
    .out_data_val      (out_data_val),
    .out_data_rdy      (out_data_rdy),
    .out_data          (out_data),
    .out_data_last     (out_data_last),
    .out_data_padbytes (out_data_padbytes),
    .err_len_mismatch  (err_len_mismatch),
    .pkt_cnt           (pkt_cnt)
  );

  typedef struct {
    logic [31:0] sip;
    logic [31:0] dip;
    logic [63:0] udp;
    logic [95:0] ts;
  } hdr_t;

  typedef struct {
    logic [511:0] d;
    logic         last;
    logic [5:0]   pad;
    int           pkt;
  } beat_t;

  hdr_t  hdr_q[$];
  beat_t beat_q[$];
  int    n_chk = 0;
  int    n_err = 0;
  int    hdr_pushed = 0;
  int    hdrs_got = 0;
  int    good_pkts = 0;
  int    err_exp = 0;
  int    err_seen = 0;
  bit    stall = 0;

  task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Output back-pressure: always ready unless stall mode is on
  initial begin
    out_hdr_rdy  = 1'b1;
    out_data_rdy = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (stall) begin
        out_hdr_rdy  = ($urandom_range(0, 2) != 0);
        out_data_rdy = ($urandom_range(0, 2) != 0);
      end else begin
        out_hdr_rdy  = 1'b1;
        out_data_rdy = 1'b1;
      end
    end
  end

  // Monitor: inputs only change just after posedge, so a handshake seen here
  // is the one that completes at the next posedge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (err_len_mismatch) err_seen++;
      if (out_hdr_val && out_hdr_rdy) begin
        if (hdr_q.size() == 0) begin
          chk("hdr_unexpected", 1, 0);
        end else begin
          hdr_t e;
          e = hdr_q.pop_front();
          chk("src_ip", out_src_ip, e.sip);
          chk("dst_ip", out_dst_ip, e.dip);
          chk("udp_hdr", out_udp_hdr, e.udp);
          chk("timestamp", out_timestamp, e.ts);
          hdrs_got++;
        end
      end
      if (out_data_val && out_data_rdy) begin
        if (beat_q.size() == 0) begin
          chk("beat_unexpected", 1, 0);
        end else begin
          beat_t b;
          b = beat_q.pop_front();
          chk("beat_data", out_data, b.d);
          chk("beat_last", out_data_last, b.last);
          chk("beat_pad", out_data_padbytes, b.pad);
          chk("hdr_before_data", b.pkt < hdrs_got, 1);
        end
      end
    end
  end

  task automatic send_flit(input logic [511:0] d);
    int unsigned gap;
    bit done;
    int cyc;
    gap = stall ? $urandom_range(0, 2) : 0;
    noc_in_val = 1'b0;
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
    noc_in_val  = 1'b1;
    noc_in_data = d;
    done = 0;
    cyc  = 0;
    while (!done && cyc < 1000) begin
      @(negedge clk);
      if (noc_in_rdy) done = 1;
      else cyc++;
    end
    chk("flit_accept", done, 1);
    @(posedge clk);
    #1;
    noc_in_val = 1'b0;
  endtask

  // Build flits, predict the outcome from the length rules, then drive.
  // stop_at >= 0 leaves that payload flit presented without waiting for it.
  task automatic send_packet(input int ml, input int dl, input logic [15:0] sp,
                             input logic [15:0] dp, input int stop_at);
    logic [511:0] f;
    logic [31:0]  sip, dip, pid;
    logic [63:0]  ts;
    int           exp_f, nflits, r;
    bit           ok;
    hdr_t         h;
    beat_t        b;
    sip = $urandom;
    dip = $urandom;
    pid = $urandom;
    ts  = {$urandom, $urandom};
    exp_f  = (dl + 63) / 64;
    ok     = (ml != 0) && (ml - 1 == exp_f);
    nflits = (ml > 0) ? ml - 1 : 0;
    r      = dl % 64;
    if (ok) begin
      h.sip = sip;
      h.dip = dip;
      h.udp = {sp, dp, 16'(dl + 8), 16'h0000};
      h.ts  = {pid, ts};
      hdr_q.push_back(h);
      hdr_pushed++;
      good_pkts++;
    end else begin
      err_exp++;
    end
    f = rnd512();
    f[447:426] = 22'(ml);
    f[417:386] = pid;
    f[385:322] = ts;
    send_flit(f);
    f = rnd512();
    f[511:480] = sip;
    f[479:448] = dip;
    f[447:432] = sp;
    f[431:416] = dp;
    f[415:400] = 16'(dl);
    send_flit(f);
    for (int i = 0; i < nflits; i++) begin
      f = rnd512();
      if (ok) begin
        b.d    = f;
        b.last = (i == nflits - 1);
        b.pad  = (b.last && r != 0) ? 6'(64 - r) : 6'd0;
        b.pkt  = hdr_pushed - 1;
        beat_q.push_back(b);
      end
      if (i == stop_at) begin
        noc_in_val  = 1'b1;
        noc_in_data = f;
        return;
      end
      send_flit(f);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    repeat (3) @(posedge clk);
    while ((hdr_q.size() != 0 || beat_q.size() != 0) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    chk("drain", hdr_q.size() + beat_q.size(), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    rst_n       = 1'b0;
    noc_in_val  = 1'b0;
    noc_in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_noc_rdy", noc_in_rdy, 0);
    chk("rst_hdr_val", out_hdr_val, 0);
    chk("rst_data_val", out_data_val, 0);
    chk("rst_err", err_len_mismatch, 0);
    chk("rst_pkt_cnt", pkt_cnt, 0);
    chk("rst_udp_hdr", out_udp_hdr, 64'h0000_0000_0008_0000);
    chk("rst_timestamp", out_timestamp, 0);
    chk("rst_src_ip", out_src_ip, 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rdy_before_edge", noc_in_rdy, 0);
    @(posedge clk);
    #1 chk("rdy_after_edge", noc_in_rdy, 1);

    // Directed length cases
    send_packet(3, 100, 16'd1000, 16'd2000, -1);
    wait_idle();
    chk("pkt_cnt_a", pkt_cnt, 1);
    send_packet(3, 128, 16'd7, 16'd9, -1);
    wait_idle();
    chk("pkt_cnt_b", pkt_cnt, 2);
    send_packet(1, 0, 16'd11, 16'd12, -1);
    wait_idle();
    chk("pkt_cnt_zero_len", pkt_cnt, 3);
    send_packet(2, 64, 16'd13, 16'd14, -1);
    wait_idle();
    chk("pkt_cnt_after_zero", pkt_cnt, 4);

    e0 = err_seen;
    send_packet(4, 100, 16'd1, 16'd2, -1);
    wait_idle();
    chk("err_one_cycle", err_seen - e0, 1);
    chk("pkt_cnt_mismatch", pkt_cnt, 4);

    e0 = err_seen;
    send_packet(0, 50, 16'd3, 16'd4, -1);
    send_packet(1, 5, 16'd5, 16'd6, -1);
    wait_idle();
    chk("err_short", err_seen - e0, 2);
    send_packet(2, 10, 16'd15, 16'd16, -1);
    wait_idle();
    chk("pkt_cnt_recover", pkt_cnt, 5);

    // Random packets with stalls on every handshake
    stall = 1;
    for (int p = 0; p < 50; p++) begin
      int dl, ex, ml;
      dl = $urandom_range(0, 400);
      ex = (dl + 63) / 64;
      ml = ex + 1;
      if ($urandom_range(0, 7) == 0) begin
        if ($urandom_range(0, 1) == 1) ml = ex + 2;
        else ml = (ex == 0) ? 0 : ex;
      end
      send_packet(ml, dl, 16'($urandom), 16'($urandom), -1);
    end
    wait_idle();
    stall = 0;
    chk("err_total", err_seen, err_exp);
    chk("pkt_cnt_random", pkt_cnt, good_pkts);

    // Reset during the second payload beat
    send_packet(3, 100, 16'd1000, 16'd2000, 1);
    @(negedge clk);
    chk("beat2_visible", out_data_val, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_noc_rdy", noc_in_rdy, 0);
    chk("mid_rst_data_val", out_data_val, 0);
    chk("mid_rst_hdr_val", out_hdr_val, 0);
    chk("mid_rst_err", err_len_mismatch, 0);
    chk("mid_rst_pkt_cnt", pkt_cnt, 0);
    noc_in_val = 1'b0;
    hdr_q.delete();
    beat_q.delete();
    hdr_pushed = 0;
    hdrs_got   = 0;
    good_pkts  = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1 chk("rdy_after_mid_rst", noc_in_rdy, 0);
    send_packet(3, 100, 16'd1000, 16'd2000, -1);
    wait_idle();
    chk("pkt_cnt_restart", pkt_cnt, 1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
